// File: rtl/traffic_light_monitor_if.sv
// Observation bus between the light controller lamps and the monitor.
// master drives the lamps and clr; slave reports phase, times and errors.
interface traffic_light_monitor_if #(
    parameter int TW = 7
);
    logic          led4_r;
    logic          led4_g;
    logic          led4_b;
    logic          led5_r;
    logic          led5_g;
    logic          led5_b;
    logic          clr;
    logic [2:0]    phase;
    logic [TW-1:0] t_red;
    logic [TW-1:0] t_green;
    logic [TW-1:0] t_yellow;
    logic          cyc_done;
    logic [7:0]    cyc_cnt;
    logic          err;
    logic [1:0]    err_code;

    modport master (
        output led4_r, led4_g, led4_b,
        output led5_r, led5_g, led5_b,
        output clr,
        input  phase, t_red, t_green, t_yellow,
        input  cyc_done, cyc_cnt, err, err_code
    );

    modport slave (
        input  led4_r, led4_g, led4_b,
        input  led5_r, led5_g, led5_b,
        input  clr,
        output phase, t_red, t_green, t_yellow,
        output cyc_done, cyc_cnt, err, err_code
    );
endinterface

// File: rtl/traffic_light_monitor.sv
// Passive six-phase traffic-light cycle tracker with phase timing and sticky errors.
// Optional build macro MON_SYMMETRY_CHECK_EN compares lamp-5 phase times to lamp-4.
module traffic_light_monitor #(
    parameter int TW = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    traffic_light_monitor_if.slave  mon
);

    typedef enum logic [2:0] {
        C_OFF = 3'd0,
        C_RED = 3'd1,
        C_GRN = 3'd2,
        C_YEL = 3'd3,
        C_ILL = 3'd4
    } colour_e;

    typedef enum logic [2:0] {
        HUNT = 3'd0,
        RR1  = 3'd1,
        GR   = 3'd2,
        YR   = 3'd3,
        RR2  = 3'd4,
        RG   = 3'd5,
        RY   = 3'd6,
        ERR  = 3'd7
    } state_e;

    localparam logic [5:0] P_RR = {C_RED, C_RED};

    function automatic colour_e decode(input logic r, input logic g, input logic b);
        case ({r, g, b})
            3'b100:  return C_RED;
            3'b010:  return C_GRN;
            3'b110:  return C_YEL;
            3'b000:  return C_OFF;
            default: return C_ILL;
        endcase
    endfunction

    function automatic logic [5:0] pat_of(input state_e s);
        case (s)
            RR1, RR2: return {C_RED, C_RED};
            GR:       return {C_GRN, C_RED};
            YR:       return {C_YEL, C_RED};
            RG:       return {C_RED, C_GRN};
            RY:       return {C_RED, C_YEL};
            default:  return {C_OFF, C_OFF};
        endcase
    endfunction

    function automatic state_e next_of(input state_e s);
        case (s)
            RR1:     return GR;
            GR:      return YR;
            YR:      return RR2;
            RR2:     return RG;
            RG:      return RY;
            RY:      return RR1;
            default: return HUNT;
        endcase
    endfunction

    state_e        state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d, cnt_sat;
    logic [TW-1:0] red4_q, red4_d;
    logic [TW-1:0] green4_q, green4_d;
    logic [TW-1:0] yellow4_q, yellow4_d;
`ifdef MON_SYMMETRY_CHECK_EN
    logic [TW-1:0] red5_q, red5_d;
    logic [TW-1:0] green5_q, green5_d;
`endif
    logic [TW-1:0] t_red_q, t_red_d;
    logic [TW-1:0] t_green_q, t_green_d;
    logic [TW-1:0] t_yellow_q, t_yellow_d;
    logic          cyc_done_q, cyc_done_d;
    logic [7:0]    cyc_cnt_q, cyc_cnt_d;
    logic          err_q, err_d;
    logic [1:0]    err_code_q, err_code_d;

    colour_e    c4, c5;
    logic [5:0] pat;
    logic       illegal;
    logic [1:0] err_ev;

    assign c4      = decode(mon.led4_r, mon.led4_g, mon.led4_b);
    assign c5      = decode(mon.led5_r, mon.led5_g, mon.led5_b);
    assign pat     = {c4, c5};
    assign illegal = (c4 == C_ILL) || (c5 == C_ILL);
    assign cnt_sat = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        red4_d     = red4_q;
        green4_d   = green4_q;
        yellow4_d  = yellow4_q;
`ifdef MON_SYMMETRY_CHECK_EN
        red5_d     = red5_q;
        green5_d   = green5_q;
`endif
        t_red_d    = t_red_q;
        t_green_d  = t_green_q;
        t_yellow_d = t_yellow_q;
        cyc_done_d = 1'b0;
        cyc_cnt_d  = cyc_cnt_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        err_ev     = 2'd0;

        if (mon.clr) begin
            err_d      = 1'b0;
            err_code_d = 2'd0;
        end

        unique case (state_q)
            HUNT: begin
                if (pat == P_RR) begin
                    state_d = RR1;
                    cnt_d   = TW'(1);
                end
            end
            ERR: begin
                if (mon.clr) begin
                    state_d = HUNT;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (illegal) begin
                    err_ev  = 2'd1;
                    state_d = ERR;
                end else if (pat == pat_of(state_q)) begin
                    cnt_d = cnt_sat;
                end else if (pat == pat_of(next_of(state_q))) begin
                    state_d = next_of(state_q);
                    cnt_d   = TW'(1);
                    case (state_q)
                        RR1: red4_d    = cnt_q;
                        GR:  green4_d  = cnt_q;
                        YR:  yellow4_d = cnt_q;
`ifdef MON_SYMMETRY_CHECK_EN
                        RR2: red5_d    = cnt_q;
                        RG:  green5_d  = cnt_q;
`endif
                        RY: begin
                            t_red_d    = red4_q;
                            t_green_d  = green4_q;
                            t_yellow_d = yellow4_q;
                            cyc_done_d = 1'b1;
                            cyc_cnt_d  = cyc_cnt_q + 8'd1;
`ifdef MON_SYMMETRY_CHECK_EN
                            // yellow5 is the count being closed right now
                            if (red5_q != red4_q || green5_q != green4_q ||
                                cnt_q != yellow4_q)
                                err_ev = 2'd3;
`endif
                        end
                        default: ;
                    endcase
                end else begin
                    err_ev  = 2'd2;
                    state_d = ERR;
                end
            end
        endcase

        // A fresh error beats a same-cycle clr; otherwise the first cause sticks
        if (err_ev != 2'd0) begin
            err_d = 1'b1;
            if (!err_q || mon.clr)
                err_code_d = err_ev;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= HUNT;
            cnt_q      <= '0;
            red4_q     <= '0;
            green4_q   <= '0;
            yellow4_q  <= '0;
`ifdef MON_SYMMETRY_CHECK_EN
            red5_q     <= '0;
            green5_q   <= '0;
`endif
            t_red_q    <= '0;
            t_green_q  <= '0;
            t_yellow_q <= '0;
            cyc_done_q <= 1'b0;
            cyc_cnt_q  <= '0;
            err_q      <= 1'b0;
            err_code_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            red4_q     <= red4_d;
            green4_q   <= green4_d;
            yellow4_q  <= yellow4_d;
`ifdef MON_SYMMETRY_CHECK_EN
            red5_q     <= red5_d;
            green5_q   <= green5_d;
`endif
            t_red_q    <= t_red_d;
            t_green_q  <= t_green_d;
            t_yellow_q <= t_yellow_d;
            cyc_done_q <= cyc_done_d;
            cyc_cnt_q  <= cyc_cnt_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign mon.phase    = state_q;
    assign mon.t_red    = t_red_q;
    assign mon.t_green  = t_green_q;
    assign mon.t_yellow = t_yellow_q;
    assign mon.cyc_done = cyc_done_q;
    assign mon.cyc_cnt  = cyc_cnt_q;
    assign mon.err      = err_q;
    assign mon.err_code = err_code_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed scenarios plus random lamp traffic,
// checked every cycle against a phase-table model of the light cycle.
module tb_traffic_light_monitor;

    localparam int TW  = 7;
    localparam int MAX = (1 << TW) - 1;

    // colour ids: 0 OFF, 1 RED, 2 GREEN, 3 YELLOW, 4 ILLEGAL
    localparam int OFF = 0;
    localparam int RED = 1;
    localparam int GRN = 2;
    localparam int YEL = 3;
    localparam int ILL = 4;

`ifdef MON_SYMMETRY_CHECK_EN
    localparam int SYM = 1;
`else
    localparam int SYM = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    traffic_light_monitor_if #(.TW(TW)) bus ();

    traffic_light_monitor #(.TW(TW)) dut (
        .clk (clk),
        .rst (rst),
        .mon (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int seq4 [1:6] = '{RED, GRN, YEL, RED, RED, RED};
    int seq5 [1:6] = '{RED, RED, RED, RED, GRN, YEL};

    int m_ph, m_cnt, m_tr, m_tg, m_ty, m_done, m_cyc, m_err, m_code;
    int m_slot [1:6];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures < 40)
                $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int mdec(input logic r, input logic g, input logic b);
        if (b) return ILL;
        if (r && !g) return RED;
        if (!r && g) return GRN;
        if (r && g) return YEL;
        return OFF;
    endfunction

    function automatic logic [2:0] enc(input int c);
        logic [1:0] rg;
        case (c)
            RED:     return 3'b100;
            GRN:     return 3'b010;
            YEL:     return 3'b110;
            OFF:     return 3'b000;
            default: begin
                rg = 2'($urandom_range(0, 3));
                return {rg, 1'b1};
            end
        endcase
    endfunction

    task automatic model_reset();
        m_ph = 0; m_cnt = 0; m_tr = 0; m_tg = 0; m_ty = 0;
        m_done = 0; m_cyc = 0; m_err = 0; m_code = 0;
        for (int i = 1; i <= 6; i++) m_slot[i] = 0;
    endtask

    task automatic model_step();
        int c4, c5, ev, nx;
        c4 = mdec(bus.led4_r, bus.led4_g, bus.led4_b);
        c5 = mdec(bus.led5_r, bus.led5_g, bus.led5_b);
        ev = 0;
        m_done = 0;
        if (bus.clr) begin m_err = 0; m_code = 0; end
        if (m_ph == 0) begin
            if (c4 == RED && c5 == RED) begin m_ph = 1; m_cnt = 1; end
        end else if (m_ph == 7) begin
            if (bus.clr) begin m_ph = 0; m_cnt = 0; end
        end else begin
            nx = (m_ph == 6) ? 1 : m_ph + 1;
            if (c4 == ILL || c5 == ILL) begin
                ev = 1; m_ph = 7;
            end else if (c4 == seq4[m_ph] && c5 == seq5[m_ph]) begin
                m_cnt = (m_cnt < MAX) ? m_cnt + 1 : MAX;
            end else if (c4 == seq4[nx] && c5 == seq5[nx]) begin
                m_slot[m_ph] = m_cnt;
                if (m_ph == 6) begin
                    m_tr = m_slot[1]; m_tg = m_slot[2]; m_ty = m_slot[3];
                    m_done = 1;
                    m_cyc = (m_cyc + 1) % 256;
                    if (SYM != 0 && (m_slot[4] != m_slot[1] ||
                        m_slot[5] != m_slot[2] || m_slot[6] != m_slot[3]))
                        ev = 3;
                end
                m_ph = nx; m_cnt = 1;
            end else begin
                ev = 2; m_ph = 7;
            end
        end
        if (ev != 0) begin
            if (m_err == 0) m_code = ev;
            m_err = 1;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    task automatic compare_all();
        check("phase",    int'(bus.phase),    m_ph);
        check("t_red",    int'(bus.t_red),    m_tr);
        check("t_green",  int'(bus.t_green),  m_tg);
        check("t_yellow", int'(bus.t_yellow), m_ty);
        check("cyc_done", int'(bus.cyc_done), m_done);
        check("cyc_cnt",  int'(bus.cyc_cnt),  m_cyc);
        check("err",      int'(bus.err),      m_err);
        check("err_code", int'(bus.err_code), m_code);
    endtask

    always @(negedge clk) compare_all();

    task automatic drive(input int p4, input int p5, input int n, input bit c = 1'b0);
        for (int i = 0; i < n; i++) begin
            {bus.led4_r, bus.led4_g, bus.led4_b} = enc(p4);
            {bus.led5_r, bus.led5_g, bus.led5_b} = enc(p5);
            bus.clr = c;
            @(negedge clk);
        end
        bus.clr = 1'b0;
    endtask

    task automatic full_cycle(input int r1, input int g, input int y,
                              input int r2, input int g5, input int y5);
        drive(RED, RED, r1);
        drive(GRN, RED, g);
        drive(YEL, RED, y);
        drive(RED, RED, r2);
        drive(RED, GRN, g5);
        drive(RED, YEL, y5);
        drive(RED, RED, 1);
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        int g, rem, r, p4, p5;
        bit cv;
        model_reset();
        {bus.led4_r, bus.led4_g, bus.led4_b} = 3'b000;
        {bus.led5_r, bus.led5_g, bus.led5_b} = 3'b000;
        bus.clr = 1'b0;
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_phase",   int'(bus.phase),   0);
        check("rst_err",     int'(bus.err),     0);
        check("rst_cyc_cnt", int'(bus.cyc_cnt), 0);
        check("rst_t_red",   int'(bus.t_red),   0);

        drive(OFF, OFF, 2);
        drive(GRN, RED, 1);
        full_cycle(3, 5, 2, 3, 5, 2);
        check("c1_done",   int'(bus.cyc_done), 1);
        check("c1_t_red",  int'(bus.t_red),    3);
        check("c1_t_grn",  int'(bus.t_green),  5);
        check("c1_t_yel",  int'(bus.t_yellow), 2);
        check("c1_cyc",    int'(bus.cyc_cnt),  1);
        check("c1_err",    int'(bus.err),      0);

        drive(RED, RED, 2);
        drive(GRN, RED, 2);
        drive(ILL, RED, 1);
        check("ill_phase", int'(bus.phase),    7);
        check("ill_err",   int'(bus.err),      1);
        check("ill_code",  int'(bus.err_code), 1);
        drive(GRN, RED, 1, 1'b1);
        check("clr_phase", int'(bus.phase),    0);
        check("clr_err",   int'(bus.err),      0);
        check("clr_t_grn", int'(bus.t_green),  5);

        drive(RED, RED, 1);
        drive(GRN, RED, 1);
        drive(RED, GRN, 1);
        check("tr_phase",  int'(bus.phase),    7);
        check("tr_code",   int'(bus.err_code), 2);
        drive(RED, ILL, 1);
        check("tr_keep",   int'(bus.err_code), 2);
        drive(OFF, OFF, 1, 1'b1);

        full_cycle(3, 5, 2, 4, 5, 2);
        check("sym_done",  int'(bus.cyc_done), 1);
        check("sym_t_red", int'(bus.t_red),    3);
        check("sym_err",   int'(bus.err),      SYM);
        check("sym_code",  int'(bus.err_code), SYM * 3);
        drive(RED, RED, 1, 1'b1);

        drive(RED, RED, 1);
        drive(GRN, RED, 200);
        drive(YEL, RED, 2);
        drive(RED, RED, 3);
        drive(RED, GRN, 200);
        drive(RED, YEL, 2);
        drive(RED, RED, 1);
        check("sat_done",  int'(bus.cyc_done), 1);
        check("sat_t_grn", int'(bus.t_green),  MAX);
        check("sat_err",   int'(bus.err),      0);

        reset_pulse();
        @(negedge clk);
        full_cycle(2, 3, 1, 2, 3, 1);
        drive(RED, RED, 1);
        drive(GRN, RED, 4);
        drive(YEL, RED, 1);
        #2 rst = 1'b1;
        #1;
        check("mrst_phase", int'(bus.phase),    0);
        check("mrst_cyc",   int'(bus.cyc_cnt),  0);
        check("mrst_t_red", int'(bus.t_red),    0);
        check("mrst_done",  int'(bus.cyc_done), 0);
        check("mrst_err",   int'(bus.err),      0);
        @(negedge clk);
        rst = 1'b0;
        full_cycle(4, 6, 3, 4, 6, 3);
        check("post_cyc",   int'(bus.cyc_cnt),  1);
        check("post_t_red", int'(bus.t_red),    4);
        check("post_t_grn", int'(bus.t_green),  6);
        check("post_t_yel", int'(bus.t_yellow), 3);

        g = 6;
        rem = 0;
        for (int k = 0; k < 4000; k++) begin
            r = int'($urandom_range(0, 999));
            if (rem == 0) begin
                g = (g == 6) ? 1 : g + 1;
                rem = (r % 97 == 0) ? int'($urandom_range(125, 140))
                                    : int'($urandom_range(1, 6));
            end
            rem--;
            p4 = seq4[g];
            p5 = seq5[g];
            if (r < 12) begin
                if (r < 6) p4 = ILL; else p5 = ILL;
            end else if (r < 25) begin
                p4 = int'($urandom_range(0, 3));
                p5 = int'($urandom_range(0, 3));
            end
            cv = (r >= 975);
            if (r == 500) begin
                reset_pulse();
                g = 6;
                rem = 0;
            end
            drive(p4, p5, 1, cv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Passive observer for the dual RGB traffic-light outputs (led4/led5) of the light controller. It decodes both lamps' colour every clock and tracks the six-phase traffic cycle with a state machine. It measures each phase's duration in clock cycles and reports the red, green and yellow times of the last completed cycle, along with sticky protocol errors. It sits beside the controller on the same clock, for on-board self-check and bench scoreboarding.

## Interface
- TW, 7: width of phase-duration counters and reported times.
- clk  in  1  clock; all inputs are sampled on its rising edge (same domain as the controller, no synchronizer).
- rst  in  1  reset, asynchronous, active-high.
- led4_r, led4_g, led4_b  in  1 each  observed lamp 4 colour bits.
- led5_r, led5_g, led5_b  in  1 each  observed lamp 5 colour bits.
- clr  in  1  synchronous clear of err/err_code; returns FSM from ERR to HUNT.
- phase  out  3  current FSM state code.
- t_red, t_green, t_yellow  out  TW each  durations from the last completed cycle.
- cyc_done  out  1  one-cycle pulse when the t_* outputs update.
- cyc_cnt  out  8  completed-cycle count; wraps 255→0.
- err  out  1  sticky error flag.
- err_code  out  2  first error cause: 1 = illegal colour, 2 = illegal transition, 3 = asymmetry.

## Operation
- Per-lamp colour decode of {r,g,b}:
  - 100 RED, 010 GREEN, 110 YELLOW, 000 OFF.
  - Any other value is ILLEGAL, including any b=1.
- Pattern is the pair (lamp4, lamp5).
- FSM states and phase codes:
  - HUNT=0, RR1=1 (RED,RED), GR=2 (GREEN,RED), YR=3 (YELLOW,RED), RR2=4 (RED,RED), RG=5 (RED,GREEN), RY=6 (RED,YELLOW), ERR=7.
- Legal sequence: RR1→GR→YR→RR2→RG→RY→RR1.
- HUNT:
  - Stays in HUNT for any pattern other than (RED,RED), OFF and ILLEGAL included; no errors are raised.
  - First (RED,RED) sample moves to RR1 with cnt=1.
- In any measuring state, for each sample:
  - Same pattern: cnt+1, saturating at 2^TW−1.
  - Next legal pattern: latch cnt into that phase's slot, cnt<=1, advance.
  - Any other pattern: go to ERR with err_code=2.
  - ILLEGAL colour on either lamp: go to ERR with err_code=1. This takes priority over code 2.
- Phase slots: RR1→red4, GR→green4, YR→yellow4, RR2→red5, RG→green5, RY→yellow5.
- Cycle completion on the RY→RR1 transition:
  - t_red<=red4, t_green<=green4, t_yellow<=yellow4.
  - cyc_done pulses; cyc_cnt+1.
- ERR state:
  - err=1; err_code holds the first cause and is not overwritten.
  - FSM stays in ERR until clr.
  - clr: err, err_code<=0, FSM→HUNT, cnt<=0. t_* and cyc_cnt are kept.
- clr in a non-ERR state clears err/err_code only.

## Timing
- Reset values: phase=0 (HUNT), t_red=t_green=t_yellow=0, cyc_done=0, cyc_cnt=0, err=0, err_code=0; all internal counters and slots are 0.
- All outputs are registered. phase reflects the pattern sampled at the same edge, i.e. 1-cycle latency from input change to phase output.
- cyc_done is high for exactly the one cycle following the edge that samples RR1 after RY. t_* are valid from that same cycle.
- A duration equals the number of consecutive samples of that pattern. The RR1 measured on the first cycle after HUNT counts from the HUNT exit sample.
- Saturation: cnt holds at 2^TW−1 with no error. The reported value is 2^TW−1.
- Simultaneous clr and error condition in the same cycle: the error wins. err=1, the new code is stored, FSM→ERR.
- rst asserted mid-cycle: all state returns to reset values immediately. No cyc_done is emitted for the partial cycle.

## Configuration
- MON_SYMMETRY_CHECK_EN:
  - Defined: at cycle completion, compare red5/green5/yellow5 against red4/green4/yellow4. Any mismatch sets err=1, err_code=3 (if err was clear). cyc_done and the t_* update still occur and the FSM continues normally (no ERR state).
  - Undefined: no comparison; the red5/green5/yellow5 slots may be omitted.

## Test plan
- Reset, then drive the pattern sequence RR×3, GR×5, YR×2, RR×3, RG×5, RY×2, RR → cyc_done pulse once; t_red=3, t_green=5, t_yellow=2; cyc_cnt=1; err=0.
- Mid-GR, drive led4_b=1 for 1 cycle → phase=7, err=1, err_code=1. Then clr for 1 cycle → phase=0, err=0, t_* unchanged.
- From GR, drive (RED,GREEN) directly → phase=7, err_code=2. Afterwards drive an ILLEGAL colour → err_code stays 2.
- Legal cycle with RR2 held 4 cycles (RR1 held 3) → with MON_SYMMETRY_CHECK_EN: err=1, err_code=3, cyc_done still pulses, t_red=3. Without the macro: err=0.
- Hold GR for 200 cycles with TW=7, then complete the cycle → t_green=127, no error.
- Assert rst during YR of the second cycle → all outputs 0, phase=0. After release, the next full cycle reports correct values with cyc_cnt=1.
